// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the wait-state data memory
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;
    localparam int DMEM_DEPTH = 64;
    localparam logic ERR_NONE = 1'b0;
    localparam logic ERR_ILLEGAL = 1'b1;
    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/wait_counter.sv
// wait_counter: 4-bit loadable down-counter with zero flag
module wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);
    logic [3:0] cnt_q, cnt_d;
    assign zero = cnt_q == 4'd0;
    always_comb cnt_d = load ? load_val : (en && !zero) ? cnt_q - 4'd1 : cnt_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= 4'd0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: fixed-latency data memory that stalls the core until each access completes
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = 3,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic [31:0]     Adr,
    input  logic [31:0]     WriteData,
    output logic [31:0]     ReadData,
    output logic            Stall,
    output logic            Done,
    output logic            Err,
    output logic [CNTW-1:0] AccessCount
);
    localparam int IW = idx_width(DEPTH);
    dmem_state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic we_q, we_d, ill_q, ill_d;
    logic [CNTW-1:0] acc_q, acc_d;
    logic [31:0] mem [DEPTH];
    logic req, illegal, cnt_zero, finish;
    assign req = MemRead | MemWrite;
    // both strobes set behaves as a write but is flagged, so nothing is stored
    assign illegal = (Adr[1:0] != 2'b00) || (Adr[31:2] >= 30'(DEPTH)) || (MemRead && MemWrite);
    assign finish = state_q == BUSY && cnt_zero;
    wait_counter u_wait (
        .clk     (clk),
        .reset   (reset),
        .load    (state_q == IDLE && req),
        .load_val(4'(LATENCY - 1)),
        .en      (state_q == BUSY),
        .zero    (cnt_zero)
    );
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        ill_d   = ill_q;
        rdata_d = rdata_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = BUSY;
                idx_d   = Adr[IW+1:2];
                wdata_d = WriteData;
                we_d    = MemWrite;
                ill_d   = illegal ? ERR_ILLEGAL : ERR_NONE;
            end
            BUSY: if (cnt_zero) begin
                state_d = DONE;
                acc_d   = acc_q + 1'b1;
                rdata_d = ill_q ? 32'd0 : we_q ? rdata_q : mem[idx_q];
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ill_q   <= ERR_NONE;
            rdata_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
            rdata_q <= rdata_d;
            acc_q   <= acc_d;
        end
    // an async reset returns state_q to IDLE, so an aborted store never reaches here
    always_ff @(posedge clk)
        if (finish && we_q && !ill_q) mem[idx_q] <= wdata_q;
    assign Stall       = reset && (state_q == BUSY || (state_q == IDLE && req));
    assign Done        = state_q == DONE;
    assign Err         = Done && ill_q;
    assign ReadData    = rdata_q;
    assign AccessCount = acc_q;
endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: table-driven check of dmem_wait_ctrl plus reset-abort and wrap sequences
module tb_dmem_wait_ctrl;
    localparam int LAT = 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] Adr = '0, WriteData = '0, ReadData;
    logic Stall, Done, Err;
    logic [15:0] AccessCount;
    logic b_rd = 1'b0;
    logic [31:0] b_rdata;
    logic b_stall, b_done, b_err;
    logic [2:0] b_cnt;
    int n_cmp = 0, n_bad = 0;
    int cnt_a = 0;
    logic [31:0] prev_rd = '0;

    typedef struct {
        logic rd, wr;
        logic [31:0] a, d;
        logic err;
        logic [31:0] rdv;
    } vec_t;
    vec_t v[16];

    always #5 clk = ~clk;

    dmem_wait_ctrl #(.DEPTH(64), .LATENCY(LAT), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Adr(Adr),
        .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .Done(Done),
        .Err(Err), .AccessCount(AccessCount)
    );

    dmem_wait_ctrl #(.DEPTH(64), .LATENCY(1), .CNTW(3)) dut_b (
        .clk(clk), .reset(reset), .MemRead(b_rd), .MemWrite(1'b0), .Adr(32'h0),
        .WriteData(32'h0), .ReadData(b_rdata), .Stall(b_stall), .Done(b_done),
        .Err(b_err), .AccessCount(b_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // called just after a rising edge with the DUT idle; returns the same way
    task automatic acc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd, input logic scr);
        int stalls = 0;
        bit seen = 0;
        MemRead = rd; MemWrite = wr; Adr = a; WriteData = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (Done) seen = 1;
            else begin
                if (Stall) stalls++;
                if (i == LAT) chk("rdata_hold", ReadData, prev_rd);
                if (scr && i >= 1) begin Adr = a ^ 32'h4; WriteData = ~d; end
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("stall_cycles", stalls, LAT + 1);
        chk("err", 32'(Err), 32'(e_err));
        chk("rdata", ReadData, e_rd);
        chk("count", 32'(AccessCount), 32'(cnt_a + 1));
        chk("stall_in_done", 32'(Stall), 32'd0);
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0;
        cnt_a++;
        prev_rd = e_rd;
        @(negedge clk);
        chk("done_pulse_end", 32'(Done), 32'd0);
        chk("idle_stall", 32'(Stall), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        v[0]  = '{1'b0, 1'b1, 32'h60, 32'd25, 1'b0, 32'd0};
        v[1]  = '{1'b1, 1'b0, 32'h60, 32'd0, 1'b0, 32'd25};
        v[2]  = '{1'b0, 1'b1, 32'h64, 32'd7, 1'b0, 32'd25};
        v[3]  = '{1'b1, 1'b0, 32'h64, 32'd0, 1'b0, 32'd7};
        v[4]  = '{1'b0, 1'b1, 32'h68, 32'd100, 1'b0, 32'd7};
        v[5]  = '{1'b0, 1'b1, 32'h62, 32'hDEAD, 1'b1, 32'd0};
        v[6]  = '{1'b1, 1'b0, 32'h60, 32'd0, 1'b0, 32'd25};
        v[7]  = '{1'b1, 1'b0, 32'h100, 32'd0, 1'b1, 32'd0};
        v[8]  = '{1'b1, 1'b1, 32'h60, 32'd9, 1'b1, 32'd0};
        v[9]  = '{1'b1, 1'b0, 32'h60, 32'd0, 1'b0, 32'd25};
        v[10] = '{1'b0, 1'b1, 32'h70, 32'h1234, 1'b0, 32'd25};
        v[11] = '{1'b0, 1'b1, 32'hFC, 32'hCAFE, 1'b0, 32'd25};
        v[12] = '{1'b1, 1'b0, 32'hFC, 32'd0, 1'b0, 32'hCAFE};
        v[13] = '{1'b1, 1'b0, 32'h8000_0060, 32'd0, 1'b1, 32'd0};
        v[14] = '{1'b1, 1'b0, 32'h63, 32'd0, 1'b1, 32'd0};
        v[15] = '{1'b1, 1'b0, 32'h70, 32'd0, 1'b0, 32'h1234};

        #2 reset = 1'b0;
        MemRead = 1'b1;
        #10;
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_count", 32'(AccessCount), 32'd0);
        MemRead = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        foreach (v[i]) acc(v[i].rd, v[i].wr, v[i].a, v[i].d, v[i].err, v[i].rdv, 1'b0);

        // inputs changed while busy must not affect the latched access
        acc(1'b0, 1'b1, 32'h68, 32'h55, 1'b0, 32'h1234, 1'b1);
        acc(1'b1, 1'b0, 32'h68, 32'd0, 1'b0, 32'h55, 1'b0);
        acc(1'b1, 1'b0, 32'h60, 32'd0, 1'b0, 32'd25, 1'b1);

        // reset asserted in the middle of a store aborts it
        MemWrite = 1'b1; Adr = 32'h70; WriteData = 32'd5;
        @(negedge clk);
        @(negedge clk);
        chk("busy_stall", 32'(Stall), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_stall", 32'(Stall), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_count", 32'(AccessCount), 32'd0);
        chk("abort_rdata", ReadData, 32'd0);
        MemWrite = 1'b0;
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        cnt_a = 0;
        prev_rd = '0;
        acc(1'b1, 1'b0, 32'h70, 32'd0, 1'b0, 32'h1234, 1'b0);

        // LATENCY=1, CNTW=3: held loads run back to back, nine accesses wrap the count to 1
        b_rd = 1'b1;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            chk("b_done", 32'(b_done), 32'(i % 3 == 2));
            chk("b_stall", 32'(b_stall), 32'(i % 3 != 2));
            if (i % 3 == 2) chk("b_err", 32'(b_err), 32'd0);
            if (i == 26) chk("b_wrap", 32'(b_cnt), 32'd1);
        end
        @(posedge clk); #1;
        b_rd = 1'b0;
        @(negedge clk);
        chk("b_idle_done", 32'(b_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
